// File: rtl/event_encoder_pkg.sv
// Shared code constants and priority helpers for the event encoder.
// Bit k of a mask corresponds to request line Ik; bit 1 (I1) has the highest priority.
package event_encoder_pkg;

   localparam logic [1:0] CODE_I1 = 2'b11;
   localparam logic [1:0] CODE_I2 = 2'b10;
   localparam logic [1:0] CODE_I3 = 2'b01;
   localparam logic [1:0] CODE_I4 = 2'b00;

   // One-hot grant of the highest-priority set bit (zero mask gives zero grant).
   function automatic logic [4:1] prio_onehot(input logic [4:1] mask);
      logic [4:1] g;
      g = '0;
      if (mask[1])      g[1] = 1'b1;
      else if (mask[2]) g[2] = 1'b1;
      else if (mask[3]) g[3] = 1'b1;
      else if (mask[4]) g[4] = 1'b1;
      return g;
   endfunction

   // Code of the highest-priority set bit; an empty mask maps to CODE_I4.
   function automatic logic [1:0] prio_code(input logic [4:1] mask);
      logic [1:0] c;
      c = CODE_I4;
      if (mask[1])      c = CODE_I1;
      else if (mask[2]) c = CODE_I2;
      else if (mask[3]) c = CODE_I3;
      return c;
   endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO with a separate occupancy counter; push is accepted when full
// only if a pop happens in the same cycle. Head reads as zero while empty.
module code_fifo #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1,
   parameter int W     = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/event_encoder.sv
// Rising-edge event encoder: per-line edge detect, sticky pending bits, fixed-priority
// arbiter feeding a code FIFO delivered over VALID/READY, with a sticky overrun flag.
module event_encoder
   import event_encoder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          I1,
   input  logic          I2,
   input  logic          I3,
   input  logic          I4,
   output logic          Y1,
   output logic          Y2,
   output logic          VALID,
   input  logic          READY,
   output logic [CW-1:0] COUNT,
   output logic          OVR,
   input  logic          OVR_CLR
);

   logic [4:1] lines;
   logic [4:1] s_q;
   logic [4:1] pend_q, pend_d;
   logic [4:1] edge_det;
   logic [4:1] grant;
   logic       ovr_q, ovr_d;
   logic       ovr_set;
   logic       fifo_full, fifo_empty;
   logic       pop, push, can_push;
   logic [1:0] push_code;
   logic [1:0] head;

   assign lines    = {I4, I3, I2, I1};
   assign edge_det = lines & ~s_q;

   assign pop      = ~fifo_empty & READY;
   assign can_push = ~fifo_full | pop;

   always_comb begin
      grant     = '0;
      push_code = prio_code(pend_q);
      if (can_push) grant = prio_onehot(pend_q);
      push      = |grant;
      // A new edge on the line being granted re-arms it instead of counting as overrun.
      pend_d    = (pend_q & ~grant) | edge_det;
      ovr_set   = |(edge_det & pend_q & ~grant);
      ovr_d     = ovr_set | (ovr_q & ~OVR_CLR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         pend_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         s_q    <= lines;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end

   code_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW),
      .W     (2)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (push_code),
      .pop_i   (READY),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (COUNT)
   );

   assign VALID = ~fifo_empty;
   assign Y1    = head[1];
   assign Y2    = head[0];
   assign OVR   = ovr_q;

endmodule

// File: tb/tb_event_encoder.sv
// Scenario bench for event_encoder: expected codes are queued as stimulus is driven
// and compared in order as the consumer accepts them.
module tb_event_encoder;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          I1, I2, I3, I4;
   logic          Y1, Y2, VALID, READY, OVR, OVR_CLR;
   logic [CW-1:0] COUNT;

   int errors = 0;
   int checks = 0;
   logic [1:0] exp_q[$];

   event_encoder #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .I1(I1), .I2(I2), .I3(I3), .I4(I4),
      .Y1(Y1), .Y2(Y2), .VALID(VALID), .READY(READY),
      .COUNT(COUNT), .OVR(OVR), .OVR_CLR(OVR_CLR)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drains the scoreboard through the handshake, comparing each accepted head.
   task automatic drain(input string name);
      logic [1:0] e;
      READY = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         if (VALID) begin
            e = exp_q.pop_front();
            checks++;
            if ({Y1, Y2} !== e) begin
               errors++;
               $display("FAIL %s_code got=%b exp=%b", name, {Y1, Y2}, e);
            end
         end
         tick();
      end
      READY = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout left=%0d exp=0", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (VALID !== 1'b0 || COUNT !== '0) begin
         errors++;
         $display("FAIL %s_empty valid=%b count=%0d exp 0/0", name, VALID, COUNT);
      end
   endtask

   // Pulses I4,I3,I2,I1 on consecutive cycles with READY low; leaves the FIFO full.
   task automatic fill_four();
      I4 = 1; tick();
      I4 = 0; I3 = 1; tick();
      I3 = 0; I2 = 1; tick();
      I2 = 0; I1 = 1; tick();
      I1 = 0; tick();
      exp_q.push_back(2'b00); exp_q.push_back(2'b01);
      exp_q.push_back(2'b10); exp_q.push_back(2'b11);
   endtask

   task automatic test_reset();
      rst_n = 0; I1 = 0; I2 = 0; I3 = 1; I4 = 0; READY = 0; OVR_CLR = 0;
      #3;
      checks++;
      if ({VALID, Y1, Y2, OVR, COUNT} !== '0) begin
         errors++;
         $display("FAIL reset_state got v=%b y=%b%b ovr=%b cnt=%0d exp all 0", VALID, Y1, Y2, OVR, COUNT);
      end
      tick();
      rst_n = 1;
      tick();
      checks++;
      if (VALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_lat1 valid=%b exp=0", VALID);
      end
      tick();
      checks++;
      if (VALID !== 1'b1 || {Y1, Y2} !== 2'b01 || COUNT !== 3'd1) begin
         errors++;
         $display("FAIL reset_held_i3 v=%b y=%b%b cnt=%0d exp 1/01/1", VALID, Y1, Y2, COUNT);
      end
      tick(); tick();
      checks++;
      if (COUNT !== 3'd1) begin
         errors++;
         $display("FAIL reset_single_event cnt=%0d exp=1", COUNT);
      end
      exp_q.push_back(2'b01);
      drain("reset");
      I3 = 0; tick();
   endtask

   task automatic test_simultaneous();
      logic [1:0] e;
      READY = 1;
      I1 = 1; I2 = 1; I3 = 1; I4 = 1;
      exp_q.push_back(2'b11); exp_q.push_back(2'b10);
      exp_q.push_back(2'b01); exp_q.push_back(2'b00);
      tick();
      I1 = 0; I2 = 0; I3 = 0; I4 = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (VALID !== 1'b1 || {Y1, Y2} !== e) begin
            errors++;
            $display("FAIL simul_order%0d v=%b y=%b%b exp 1/%b", i, VALID, Y1, Y2, e);
         end
         tick();
      end
      READY = 0;
      checks++;
      if (VALID !== 1'b0 || OVR !== 1'b0) begin
         errors++;
         $display("FAIL simul_end v=%b ovr=%b exp 0/0", VALID, OVR);
      end
   endtask

   task automatic test_full_hold();
      fill_four();
      I4 = 1; tick();
      I4 = 0; I3 = 1; tick();
      I3 = 0; tick(); tick();
      exp_q.push_back(2'b01); exp_q.push_back(2'b00);
      checks++;
      if (COUNT !== 3'd4 || VALID !== 1'b1 || {Y1, Y2} !== 2'b00) begin
         errors++;
         $display("FAIL full_sat cnt=%0d v=%b y=%b%b exp 4/1/00", COUNT, VALID, Y1, Y2);
      end
      checks++;
      if (OVR !== 1'b0) begin
         errors++;
         $display("FAIL full_no_ovr ovr=%b exp=0", OVR);
      end
      drain("full_hold");
   endtask

   task automatic test_overrun();
      fill_four();
      I2 = 1; tick();
      I2 = 0; tick();
      I2 = 1; tick();
      I2 = 0;
      exp_q.push_back(2'b10);
      checks++;
      if (OVR !== 1'b1 || COUNT !== 3'd4) begin
         errors++;
         $display("FAIL ovr_set ovr=%b cnt=%0d exp 1/4", OVR, COUNT);
      end
      tick();
      checks++;
      if (OVR !== 1'b1) begin
         errors++;
         $display("FAIL ovr_sticky ovr=%b exp=1", OVR);
      end
      OVR_CLR = 1; tick();
      OVR_CLR = 0;
      checks++;
      if (OVR !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clr ovr=%b exp=0", OVR);
      end
      drain("overrun");
   endtask

   task automatic test_push_pop_full();
      fill_four();
      I3 = 1; tick();
      I3 = 0; tick();
      READY = 1; tick();
      READY = 0;
      void'(exp_q.pop_front());
      exp_q.push_back(2'b01);
      checks++;
      if (COUNT !== 3'd4 || {Y1, Y2} !== 2'b01) begin
         errors++;
         $display("FAIL pushpop_full cnt=%0d y=%b%b exp 4/01", COUNT, Y1, Y2);
      end
      drain("pushpop");
   endtask

   task automatic test_reset_midstream();
      I4 = 1; tick();
      I4 = 0; I3 = 1; tick();
      I3 = 0; I2 = 1; tick();
      I2 = 0; I1 = 1; tick();
      I1 = 0;
      checks++;
      if (COUNT !== 3'd3) begin
         errors++;
         $display("FAIL mid_count cnt=%0d exp=3", COUNT);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({VALID, Y1, Y2, OVR, COUNT} !== '0) begin
         errors++;
         $display("FAIL mid_reset v=%b y=%b%b ovr=%b cnt=%0d exp all 0", VALID, Y1, Y2, OVR, COUNT);
      end
      tick();
      rst_n = 1;
      READY = 1;
      tick(); tick(); tick();
      checks++;
      if (VALID !== 1'b0 || COUNT !== '0) begin
         errors++;
         $display("FAIL mid_stale v=%b cnt=%0d exp 0/0", VALID, COUNT);
      end
      READY = 0;
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_full_hold();
      test_overrun();
      test_push_pop_full();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Opposite direction of the team's 2-to-4 decoder: encodes four request lines I1..I4 back into the 2-bit code (I1→11, I2→10, I3→01, I4→00).
- Sequential front end: detects rising edges on each line, arbitrates simultaneous events by fixed priority, and buffers encoded events in a small FIFO.
- Results are delivered over a valid/ready handshake to the downstream consumer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, width of COUNT; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- I1  in  1  request line, code 11, highest priority.
- I2  in  1  request line, code 10.
- I3  in  1  request line, code 01.
- I4  in  1  request line, code 00, lowest priority.
- Y1  out  1  code MSB of FIFO head.
- Y2  out  1  code LSB of FIFO head.
- VALID  out  1  FIFO non-empty; Y1/Y2 are meaningful.
- READY  in  1  consumer accepts the head when VALID&&READY at a clock edge.
- COUNT  out  CW  FIFO occupancy, 0..DEPTH.
- OVR  out  1  sticky overrun flag.
- OVR_CLR  in  1  clears OVR synchronously.

Behaviour:
- Reset (rst_n=0, async): sample regs s_q[4:1]=0, pending[4:1]=0, FIFO empty, Y1=Y2=0, VALID=0, COUNT=0, OVR=0.
- Consequence of s_q resetting to 0: a line already high at reset release produces one event.
- I1..I4 are synchronous to clk; no synchronizer inside.
- Edge detection: edge[k] = Ik & ~s_q[k]; s_q <= {I1..I4} every cycle.
- pending[k] is set at the edge where edge[k]=1.
- Arbitration: each cycle, if pending is non-zero and the FIFO can accept a push, push the code of the highest-priority pending line (I1 > I2 > I3 > I4) and clear that bit. At most one push per cycle.
- Can accept a push: COUNT<DEPTH, or COUNT==DEPTH and a pop occurs in the same cycle.
- Latency: rising edge sampled at edge n → pending at n → pushed at n+1 → VALID=1 after n+1 (2 cycles) when the FIFO was empty and no higher-priority event is pending.
- Set/clear collision: if edge[k] and a push of line k occur in the same cycle, pending[k] stays 1 (set wins). No overrun.
- Overrun: edge[k] while pending[k]=1 and line k is not being pushed that cycle → OVR<=1. The event merges; no extra entry is created.
- OVR_CLR: clears OVR at the next edge. A coincident new overrun wins (OVR stays 1).
- FIFO full: pending bits are held, never dropped. Arbitration resumes when space frees.
- Handshake: a pop occurs when VALID&&READY at a clock edge; Y1/Y2 then advance to the next entry.
- VALID, Y1, Y2 are registered or derived from registered FIFO state, with no combinational path from READY.
- Y1/Y2 are 00 whenever VALID=0.
- READY while VALID=0 has no effect.
- Simultaneous push and pop: COUNT is unchanged, including at full and at COUNT=1.
- Pointers wrap modulo DEPTH. COUNT is computed as a separate counter.
- Reset mid-operation discards all pending and queued events.
- Lines held high generate no further events; each requires a low→high transition.

Decomposition:
- Package event_encoder_pkg:
  - code constants CODE_I1=2'b11, CODE_I2=2'b10, CODE_I3=2'b01, CODE_I4=2'b00 (shared with the decoder's truth table);
  - a function for priority encoding of a 4-bit pending mask.
- Sub-module code_fifo:
  - parameterised sync FIFO, width 2, depth DEPTH, with push/pop/full/empty/count;
  - same clk/rst_n;
  - reusable elsewhere.
- Top holds the edge detector, pending register, arbiter and OVR.

Test Plan:
- Reset release with I3 held high → one entry code 01; VALID=1 two cycles after the first clock; COUNT=1.
- I1..I4 rise on the same cycle, READY=1 → outputs 11,10,01,00 on consecutive cycles; OVR=0.
- DEPTH=4, READY=0, six events on distinct cycles (I4,I3,I2,I1,I4,I3) → COUNT saturates at 4; remaining events held pending. Raise READY → all six codes delivered in order: 00,01,10,11, then 11-priority pending order for the held pair (I4 and I3 pending → 01 then 00).
- READY=0, I2 pulses twice before it is pushed (FIFO full) → OVR=1, single 10 entry. OVR_CLR=1 → OVR=0 next cycle.
- FIFO full, READY=1 and new event same cycle → COUNT stays 4; new code appended behind remaining entries.
- Assert rst_n=0 mid-stream with COUNT=3 and pending≠0 → immediately VALID=0, Y=00, COUNT=0, OVR=0; no stale codes after release.
